// File: rtl/midi_rx.sv
// MIDI serial receiver: 8N1 deserialiser with mid-bit sampling feeding a small show-ahead FIFO.
// Sticky overrun/framing flags are cleared by the CPU with rx_clr_err.
module midi_rx #(
  parameter int unsigned CLKHZ = 28000000,
  parameter int unsigned BAUD  = 31250,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       midi_in,
  input  logic       rx_rd,
  input  logic       rx_clr_err,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BitClks  = CLKHZ / BAUD;
  localparam int unsigned HalfClks = BitClks / 2;
  localparam int unsigned CntW     = $clog2(BitClks);
  localparam int unsigned AW       = $clog2(DEPTH);

  localparam logic [CntW-1:0] BitLoad  = CntW'(BitClks - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(HalfClks - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [AW:0]     PtrOne   = (AW + 1)'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, rxs_q, rxs_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            push_q, push_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [7:0]      mem_q [DEPTH];

  logic cnt_zero, fall_det, start_ok, data_tick, stop_good, stop_bad;
  logic do_pop, do_push, ovr_set;

  assign cnt_zero = (cnt_q == '0);

  // Sync chain presets to 1 so a reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= midi_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rxs_prev_q && !rxs_q) state_d = StStart;
      StStart:  if (cnt_zero) state_d = rxs_q ? StIdle : StData;
      StData:   if (cnt_zero && bit_q == 3'd7) state_d = StStop;
      StStop:   if (cnt_zero) state_d = rxs_q ? StIdle : StWaitHi;
      StWaitHi: if (rxs_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_busy   = (state_q != StIdle);
    fall_det  = 1'b0;
    start_ok  = 1'b0;
    data_tick = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle:  fall_det  = rxs_prev_q & ~rxs_q;
      StStart: start_ok  = cnt_zero & ~rxs_q;
      StData:  data_tick = cnt_zero;
      StStop: begin
        stop_good = cnt_zero & rxs_q;
        stop_bad  = cnt_zero & ~rxs_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    push_d  = stop_good;
    if (fall_det)                  cnt_d = HalfLoad;
    else if (start_ok | data_tick) cnt_d = BitLoad;
    else if (rx_busy && !cnt_zero) cnt_d = cnt_q - CntOne;
    if (start_ok) bit_d = 3'd0;
    if (data_tick) begin
      bit_d   = bit_q + 3'd1;
      shreg_d = {rxs_q, shreg_q[7:1]};
    end
  end

  // A pop frees the slot a simultaneous push needs, so that case never overruns.
  always_comb begin
    rx_empty    = (wr_ptr_q == rd_ptr_q);
    rx_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop      = rx_rd & ~rx_empty;
    do_push     = push_q & (~rx_full | do_pop);
    ovr_set     = push_q & rx_full & ~do_pop;
    wr_ptr_d    = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    overrun_d   = ovr_set | (overrun_q & ~rx_clr_err);
    frame_err_d = stop_bad | (frame_err_q & ~rx_clr_err);
    rx_data     = rx_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'h00;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_rx.sv
// Directed bench for midi_rx at a reduced 64-clock bit time; every check is an immediate assertion.
module tb_midi_rx;

  localparam int unsigned ClkHz = 2000000;
  localparam int unsigned Baud  = 31250;
  localparam int          Bit   = 64;
  localparam int          Half  = 32;

  logic       clk = 1'b0;
  logic       reset_n, midi_in, rx_rd, rx_clr_err;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, overrun, frame_err, rx_busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  midi_rx #(.CLKHZ(ClkHz), .BAUD(Baud), .DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .midi_in   (midi_in),
    .rx_rd     (rx_rd),
    .rx_clr_err(rx_clr_err),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    midi_in = 1'b0;
    tick(Bit);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      tick(Bit);
    end
    midi_in = stopv;
    tick(Bit);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
  endtask

  task automatic clr_err();
    rx_clr_err = 1'b1;
    tick(1);
    rx_clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_empty"}, {7'd0, rx_empty}, 8'd1);
    chk({tag, "_full"}, {7'd0, rx_full}, 8'd0);
    chk({tag, "_ovr"}, {7'd0, overrun}, 8'd0);
    chk({tag, "_ferr"}, {7'd0, frame_err}, 8'd0);
    chk({tag, "_busy"}, {7'd0, rx_busy}, 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'h90; seq[1] = 8'h3C; seq[2] = 8'h7F;
    midi_in = 1'b1; rx_rd = 1'b0; rx_clr_err = 1'b0; reset_n = 1'b0;
    tick(3);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick(Bit);

    // Single byte
    send_frame(8'h90, 1'b1);
    chk("t1_empty", {7'd0, rx_empty}, 8'd0);
    chk("t1_data", rx_data, 8'h90);
    chk("t1_ferr", {7'd0, frame_err}, 8'd0);
    pop();
    chk("t1_empty_after_rd", {7'd0, rx_empty}, 8'd1);
    chk("t1_data_empty", rx_data, 8'h00);

    // Back-to-back frames
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b1);
      chk("t2_full", {7'd0, rx_full}, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", rx_data, seq[i]);
      pop();
    end
    chk("t2_empty", {7'd0, rx_empty}, 8'd1);

    // Overrun
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    chk("t3_full4", {7'd0, rx_full}, 8'd1);
    chk("t3_ovr_none", {7'd0, overrun}, 8'd0);
    send_frame(8'h05, 1'b1);
    chk("t3_full", {7'd0, rx_full}, 8'd1);
    chk("t3_ovr", {7'd0, overrun}, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_data", rx_data, 8'(i));
      pop();
    end
    chk("t3_empty", {7'd0, rx_empty}, 8'd1);
    pop();
    chk("t3_rd_empty_noop", {7'd0, rx_empty}, 8'd1);
    clr_err();
    chk("t3_ovr_clr", {7'd0, overrun}, 8'd0);

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0);
    tick(3 * Bit);
    chk("t4_ferr", {7'd0, frame_err}, 8'd1);
    chk("t4_no_byte", {7'd0, rx_empty}, 8'd1);
    chk("t4_waithi_busy", {7'd0, rx_busy}, 8'd1);
    midi_in = 1'b1;
    tick(Bit);
    chk("t4_idle", {7'd0, rx_busy}, 8'd0);
    send_frame(8'hA5, 1'b1);
    chk("t4_data", rx_data, 8'hA5);
    pop();
    clr_err();
    chk("t4_ferr_clr", {7'd0, frame_err}, 8'd0);

    // Short low glitch
    midi_in = 1'b0;
    tick(14);
    midi_in = 1'b1;
    chk("t5_busy", {7'd0, rx_busy}, 8'd1);
    tick(Half);
    chk("t5_busy_done", {7'd0, rx_busy}, 8'd0);
    chk("t5_empty", {7'd0, rx_empty}, 8'd1);
    chk("t5_ferr", {7'd0, frame_err}, 8'd0);
    chk("t5_ovr", {7'd0, overrun}, 8'd0);

    // Reset mid-frame with a byte queued
    send_frame(8'h34, 1'b1);
    chk("t6_pre", rx_data, 8'h34);
    midi_in = 1'b0;
    tick(Bit);
    for (int i = 0; i < 4; i++) begin
      midi_in = seq[0][i] ^ 1'b1;
      tick(Bit);
    end
    midi_in = 1'b1;
    tick(Half);
    reset_n = 1'b0;
    tick(2);
    chk_reset_vals("t6_reset");
    reset_n = 1'b1;
    tick(2 * Bit);
    send_frame(8'h56, 1'b1);
    chk("t6_data", rx_data, 8'h56);
    pop();

    // Pop coincident with push while full: stop sampled 611 edges after the start edge
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    chk("t7_full", {7'd0, rx_full}, 8'd1);
    midi_in = 1'b0;
    tick(Bit);
    for (int i = 0; i < 8; i++) begin
      midi_in = ((i % 3) == 0);
      tick(Bit);
    end
    midi_in = 1'b1;
    tick(3 + Half + 9 * Bit - 9 * Bit);
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    tick(Bit - 36);
    chk("t7_full_after", {7'd0, rx_full}, 8'd1);
    chk("t7_ovr", {7'd0, overrun}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("t7_data", rx_data, 8'hA0 + 8'(i));
      pop();
    end
    chk("t7_new_byte", rx_data, 8'h49);
    pop();
    chk("t7_empty", {7'd0, rx_empty}, 8'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
